uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two requesters: the command/status path (echo, "*" ack, "!" error, state digits; single-cycle strobe, no backpressure) and the record-dump path (ADC/FIFO bytes; valid/ready stream with packet end marker).
- Command bytes go into a small FIFO. Dump packets are atomic on the wire, so a command byte never lands inside a binary record.
- Sits between the main command FSM / record readout logic and the UART TX core.

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter_cmd_byte_fifo.sv | 55 +++++
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding and the ASCII constants
// used by the command/status path.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = ST_IDLE,
    StIssue    = ST_ISSUE,
    StWaitAck  = ST_WAIT_ACK,
    StWaitDone = ST_WAIT_DONE
  } arbState_e;

  localparam logic [7:0] ACK_CHAR     = 8'h2A;  // "*"
  localparam logic [7:0] ERR_CHAR     = 8'h21;  // "!"
  localparam logic [7:0] DIGIT_OFFSET = 8'd48;  // "0"

  function automatic logic [7:0] digitChar(input logic [3:0] digit);
    return DIGIT_OFFSET + {4'd0, digit};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundles the command strobe, dump stream, UART write side and status outputs.
// master = requesters/UART side, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
);
  localparam int unsigned CntW = $clog2(CMD_DEPTH) + 1;

  logic [7:0]       cmd_data;
  logic             cmd_wr;
  logic [7:0]       dat_data;
  logic             dat_valid;
  logic             dat_last;
  logic             dat_ready;
  logic             dat_abort;
  logic             tx_busy;
  logic [7:0]       tx_data;
  logic             tx_wr;
  logic             in_packet;
  logic [CntW-1:0]  cmd_count;
  logic             cmd_overflow;
  logic             clr_overflow;
  logic [CNT_W-1:0] bytes_sent;

  modport master (
    output cmd_data, cmd_wr, dat_data, dat_valid, dat_last, dat_abort, tx_busy, clr_overflow,
    input  dat_ready, tx_data, tx_wr, in_packet, cmd_count, cmd_overflow, bytes_sent
  );

  modport slave (
    input  cmd_data, cmd_wr, dat_data, dat_valid, dat_last, dat_abort, tx_busy, clr_overflow,
    output dat_ready, tx_data, tx_wr, in_packet, cmd_count, cmd_overflow, bytes_sent
  );

endinterface

// File: rtl/uart_tx_arbiter_cmd_byte_fifo.sv
// Small synchronous byte FIFO for the command path. A push while full is accepted
// only when a pop frees a slot in the same cycle.
module cmd_byte_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(CMD_DEPTH):0] count
);
  localparam int unsigned PtrW = $clog2(CMD_DEPTH);
  localparam logic [PtrW-1:0] PtrOne = (PtrW)'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   DepthC = (PtrW + 1)'(CMD_DEPTH);

  logic [7:0]      mem [CMD_DEPTH];
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [PtrW:0]   cnt;
  logic            doPush, doPop;

  assign empty  = (cnt == '0);
  assign full   = (cnt == DepthC);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];
  assign count  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrOne;
      if (doPop)  rdPtr <= rdPtr + PtrOne;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + CntOne;
        2'b01:   cnt <= cnt - CntOne;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the command strobe path (queued in a FIFO)
// and the record-dump stream, keeping dump packets contiguous on the wire.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] SentOne = (CNT_W)'(1);

  arbState_e                  stateQ, stateD;
  logic                       inPacketQ, inPacketD;
  logic [7:0]                 txDataQ, txDataD;
  logic [CNT_W-1:0]           bytesSentQ;
  logic                       overflowQ;
  logic                       datReady;
  logic                       fifoPop, fifoFull, fifoEmpty;
  logic [7:0]                 fifoHead;
  logic [$clog2(CMD_DEPTH):0] fifoCount;
  logic                       dropped;

  cmd_byte_fifo #(
    .CMD_DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_wr),
    .pop   (fifoPop),
    .din   (bus.cmd_data),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign dropped = bus.cmd_wr && fifoFull && !fifoPop;

  always_comb begin
    stateD    = stateQ;
    inPacketD = inPacketQ;
    txDataD   = txDataQ;
    fifoPop   = 1'b0;
    datReady  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (!bus.tx_busy) begin
          if (inPacketQ) begin
            // Inside a packet only dump bytes may go out; commands wait.
            if (bus.dat_valid) begin
              datReady  = 1'b1;
              txDataD   = bus.dat_data;
              inPacketD = !bus.dat_last;
              stateD    = StIssue;
            end
          end else if (!fifoEmpty) begin
            fifoPop = 1'b1;
            txDataD = fifoHead;
            stateD  = StIssue;
          end else if (bus.dat_valid) begin
            datReady  = 1'b1;
            txDataD   = bus.dat_data;
            inPacketD = !bus.dat_last;
            stateD    = StIssue;
          end
        end
      end
      StIssue:    stateD = StWaitAck;
      StWaitAck:  stateD = StWaitDone;
      StWaitDone: if (!bus.tx_busy) stateD = StIdle;
      default:    stateD = StIdle;
    endcase
    // Abort ends the packet but never cancels a byte already granted.
    if (bus.dat_abort) inPacketD = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= StIdle;
      inPacketQ  <= 1'b0;
      txDataQ    <= 8'h00;
      bytesSentQ <= '0;
      overflowQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      inPacketQ <= inPacketD;
      txDataQ   <= txDataD;
      if (stateQ == StIssue) bytesSentQ <= bytesSentQ + SentOne;
      if (dropped)               overflowQ <= 1'b1;
      else if (bus.clr_overflow) overflowQ <= 1'b0;
    end
  end

  assign bus.tx_wr        = (stateQ == StIssue);
  assign bus.tx_data      = txDataQ;
  assign bus.dat_ready    = datReady;
  assign bus.in_packet    = inPacketQ;
  assign bus.cmd_count    = fifoCount;
  assign bus.cmd_overflow = overflowQ;
  assign bus.bytes_sent   = bytesSentQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model and a log of
// every byte written to the UART.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int unsigned CMD_DEPTH = 4;
  localparam int unsigned CNT_W     = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic forceBusy;
  int   busyCnt = 0;
  logic [7:0] sent [$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.CMD_DEPTH(CMD_DEPTH), .CNT_W(CNT_W)) bus ();

  uart_tx_arbiter #(
    .CMD_DEPTH (CMD_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // UART model: busy from the cycle after tx_wr for four cycles.
  always @(posedge clk) begin
    if (bus.tx_wr) begin
      busyCnt <= 4;
      sent.push_back(bus.tx_data);
    end else if (busyCnt != 0) begin
      busyCnt <= busyCnt - 1;
    end
  end

  assign bus.tx_busy = (busyCnt != 0) || forceBusy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic pushCmd(input logic [7:0] b);
    bus.cmd_data = b;
    bus.cmd_wr   = 1'b1;
    tick();
    bus.cmd_wr   = 1'b0;
  endtask

  task automatic sendDump(input logic [7:0] b, input logic last);
    logic got;
    got = 1'b0;
    bus.dat_data  = b;
    bus.dat_last  = last;
    bus.dat_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (bus.dat_ready) got = 1'b1;
      tick();
    end
    bus.dat_valid = 1'b0;
    bus.dat_last  = 1'b0;
    check("dump_grant", 32'(got), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_tx_wr"}, 32'(bus.tx_wr), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_dat_ready"}, 32'(bus.dat_ready), 32'd0);
    check({tag, "_in_packet"}, 32'(bus.in_packet), 32'd0);
    check({tag, "_cmd_count"}, 32'(bus.cmd_count), 32'd0);
    check({tag, "_overflow"}, 32'(bus.cmd_overflow), 32'd0);
    check({tag, "_bytes_sent"}, 32'(bus.bytes_sent), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    logic seen;
    logic [7:0] exp5 [5];

    rst_n            = 1'b0;
    forceBusy        = 1'b0;
    bus.cmd_data     = 8'h00;
    bus.cmd_wr       = 1'b0;
    bus.dat_data     = 8'h00;
    bus.dat_valid    = 1'b0;
    bus.dat_last     = 1'b0;
    bus.dat_abort    = 1'b0;
    bus.clr_overflow = 1'b0;
    waitCycles(3);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    // Single command byte on an idle system.
    pushCmd(ACK_CHAR);
    check("ack_no_wr_yet", 32'(bus.tx_wr), 32'd0);
    tick();
    check("ack_tx_wr", 32'(bus.tx_wr), 32'd1);
    check("ack_tx_data", 32'(bus.tx_data), 32'h2A);
    tick();
    check("ack_wr_pulse", 32'(bus.tx_wr), 32'd0);
    check("ack_bytes_sent", 32'(bus.bytes_sent), 32'd1);
    pushCmd(ERR_CHAR);
    n = 1;
    while (!bus.tx_wr && n < 30) begin
      tick();
      n++;
    end
    check("next_grant_after_busy", 32'(n), 32'd6);
    check("err_tx_data", 32'(bus.tx_data), 32'h21);
    waitCycles(15);
    check("two_bytes_sent", 32'(bus.bytes_sent), 32'd2);

    // Dump packet with a command byte queued mid-packet.
    base = sent.size();
    sendDump(8'h10, 1'b0);
    check("pkt_in_packet_start", 32'(bus.in_packet), 32'd1);
    sendDump(8'h11, 1'b0);
    sendDump(8'h12, 1'b0);
    pushCmd(ERR_CHAR);
    check("pkt_cmd_queued", 32'(bus.cmd_count), 32'd1);
    check("pkt_in_packet_mid", 32'(bus.in_packet), 32'd1);
    sendDump(8'h13, 1'b1);
    check("pkt_in_packet_end", 32'(bus.in_packet), 32'd0);
    waitCycles(30);
    exp5[0] = 8'h10; exp5[1] = 8'h11; exp5[2] = 8'h12; exp5[3] = 8'h13; exp5[4] = 8'h21;
    check("pkt_count", 32'(sent.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) check("pkt_order", 32'(sent[base + i]), 32'(exp5[i]));

    // Overflow while the UART is held busy.
    forceBusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_data = 8'h41 + 8'(i);
      bus.cmd_wr   = 1'b1;
      tick();
    end
    bus.cmd_wr = 1'b0;
    check("ovf_count", 32'(bus.cmd_count), 32'd4);
    check("ovf_flag", 32'(bus.cmd_overflow), 32'd1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("ovf_cleared", 32'(bus.cmd_overflow), 32'd0);
    base = sent.size();
    forceBusy = 1'b0;
    waitCycles(60);
    check("ovf_sent_count", 32'(sent.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("ovf_order", 32'(sent[base + i]), 32'h41 + 32'(i));

    // Mid-packet stall with queued commands, released by abort.
    base = sent.size();
    sendDump(8'h50, 1'b0);
    pushCmd(digitChar(4'd1));
    pushCmd(digitChar(4'd2));
    waitCycles(20);
    check("stall_sent", 32'(sent.size() - base), 32'd1);
    check("stall_cmd_count", 32'(bus.cmd_count), 32'd2);
    check("stall_in_packet", 32'(bus.in_packet), 32'd1);
    bus.dat_abort = 1'b1;
    tick();
    bus.dat_abort = 1'b0;
    check("abort_in_packet", 32'(bus.in_packet), 32'd0);
    waitCycles(40);
    check("abort_sent", 32'(sent.size() - base), 32'd3);
    check("abort_cmd1", 32'(sent[base + 1]), 32'h31);
    check("abort_cmd2", 32'(sent[base + 2]), 32'h32);

    // Push and pop in the same cycle while full.
    base = sent.size();
    forceBusy = 1'b1;
    for (int i = 0; i < 4; i++) pushCmd(8'h61 + 8'(i));
    check("full_count", 32'(bus.cmd_count), 32'd4);
    bus.cmd_data = 8'h65;
    bus.cmd_wr   = 1'b1;
    forceBusy    = 1'b0;
    tick();
    bus.cmd_wr = 1'b0;
    check("pushpop_count", 32'(bus.cmd_count), 32'd4);
    check("pushpop_no_ovf", 32'(bus.cmd_overflow), 32'd0);
    waitCycles(80);
    check("pushpop_sent", 32'(sent.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) check("pushpop_order", 32'(sent[base + i]), 32'h61 + 32'(i));

    // Reset while waiting for the UART to finish.
    pushCmd(8'h70);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.tx_wr) seen = 1'b1;
      else tick();
    end
    check("rst_pre_tx_wr", 32'(seen), 32'd1);
    tick();
    pushCmd(8'h71);
    check("rst_pre_queued", 32'(bus.cmd_count), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    base = sent.size();
    pushCmd(8'h72);
    waitCycles(30);
    check("post_rst_sent", 32'(sent.size() - base), 32'd1);
    check("post_rst_data", 32'(sent[base]), 32'h72);
    check("post_rst_bytes", 32'(bus.bytes_sent), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
